solver_assignment_controller: RTL and testbench

SOLVER_ASSIGNMENT_CONTROLLER -- requirements
Module: solver_assignment_controller

---
 rtl/solver_assignment_controller_if.sv | 22 ++
 rtl/solver_assignment_controller.sv | 132 +++++++++++++
 tb/tb_solver_assignment_controller.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/solver_assignment_controller_if.sv
// Proposal channel between a candidate-generating engine (master) and the
// assignment controller (slave); rand_byte travels with each candidate.
interface solver_assignment_controller_if #(
  parameter int ASSIGN_W   = 20,
  parameter int COST_WIDTH = 8
);
  logic                  prop_valid;
  logic                  prop_ready;
  logic [ASSIGN_W-1:0]   prop_assignment;
  logic [COST_WIDTH-1:0] prop_cost;
  logic [7:0]            rand_byte;

  modport master (
    output prop_valid, prop_assignment, prop_cost, rand_byte,
    input  prop_ready
  );

  modport slave (
    input  prop_valid, prop_assignment, prop_cost, rand_byte,
    output prop_ready
  );
endinterface

// File: rtl/solver_assignment_controller.sv
// Local-search controller: keeps a current and a best assignment, accepts
// candidates by cost or by a Metropolis test, and stops on cost 0 or budget.
module solver_assignment_controller #(
  parameter  int NUM_BOOL   = 4,
  parameter  int NUM_INT    = 2,
  parameter  int INT_WIDTH  = 8,
  parameter  int COST_WIDTH = 8,
  parameter  int ITER_WIDTH = 16,
  localparam int ASSIGN_W   = NUM_BOOL + NUM_INT * INT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ASSIGN_W-1:0]   initial_assignment,
  input  logic [COST_WIDTH-1:0] initial_cost,
  input  logic [ITER_WIDTH-1:0] max_iterations,
  input  logic [7:0]            temperature,
  solver_assignment_controller_if.slave prop,
  output logic [ASSIGN_W-1:0]   current_assignment,
  output logic [COST_WIDTH-1:0] current_cost,
  output logic [ASSIGN_W-1:0]   solution,
  output logic [COST_WIDTH-1:0] best_cost,
  output logic [ITER_WIDTH-1:0] iteration_count,
  output logic                  busy,
  output logic                  done,
  output logic                  solved
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                state_q,     state_d;
  logic [ASSIGN_W-1:0]   cur_asg_q,   cur_asg_d;
  logic [COST_WIDTH-1:0] cur_cost_q,  cur_cost_d;
  logic [ASSIGN_W-1:0]   sol_q,       sol_d;
  logic [COST_WIDTH-1:0] best_cost_q, best_cost_d;
  logic [ITER_WIDTH-1:0] iter_q,      iter_d;
  logic [ITER_WIDTH-1:0] max_iter_q,  max_iter_d;
  logic [7:0]            temp_q,      temp_d;

  logic [COST_WIDTH-1:0] delta;
  logic [7:0]            thr;
  logic                  accept;
  logic [ITER_WIDTH-1:0] iter_inc;

  // Metropolis threshold halves per unit of cost increase; 8+ steps reach zero.
  always_comb begin
    delta    = prop.prop_cost - cur_cost_q;
    thr      = (delta >= COST_WIDTH'(8)) ? 8'd0 : (temp_q >> delta);
    accept   = (prop.prop_cost <= cur_cost_q) || (prop.rand_byte < thr);
    iter_inc = (iter_q == '1) ? iter_q : iter_q + ITER_WIDTH'(1);
  end

  // NOTE: every *_d gets its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cur_asg_d   = cur_asg_q;
    cur_cost_d  = cur_cost_q;
    sol_d       = sol_q;
    best_cost_d = best_cost_q;
    iter_d      = iter_q;
    max_iter_d  = max_iter_q;
    temp_d      = temp_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cur_asg_d   = initial_assignment;
          cur_cost_d  = initial_cost;
          sol_d       = initial_assignment;
          best_cost_d = initial_cost;
          iter_d      = '0;
          max_iter_d  = max_iterations;
          temp_d      = temperature;
          state_d     = (initial_cost == '0 || max_iterations == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (prop.prop_valid) begin
          iter_d = iter_inc;
          if (accept) begin
            cur_asg_d  = prop.prop_assignment;
            cur_cost_d = prop.prop_cost;
          end
          // Strict improvement only, so the first assignment at a cost wins ties.
          if (prop.prop_cost < best_cost_q) begin
            sol_d       = prop.prop_assignment;
            best_cost_d = prop.prop_cost;
          end
          if ((accept && prop.prop_cost == '0) || iter_inc == max_iter_q)
            state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_asg_q   <= '0;
      cur_cost_q  <= '0;
      sol_q       <= '0;
      best_cost_q <= '0;
      iter_q      <= '0;
      max_iter_q  <= '0;
      temp_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_asg_q   <= cur_asg_d;
      cur_cost_q  <= cur_cost_d;
      sol_q       <= sol_d;
      best_cost_q <= best_cost_d;
      iter_q      <= iter_d;
      max_iter_q  <= max_iter_d;
      temp_q      <= temp_d;
    end
  end

  assign prop.prop_ready     = (state_q == S_RUN);
  assign busy                = (state_q == S_RUN);
  assign done                = (state_q == S_DONE);
  assign solved              = (state_q == S_DONE) && (best_cost_q == '0);
  assign current_assignment  = cur_asg_q;
  assign current_cost        = cur_cost_q;
  assign solution            = sol_q;
  assign best_cost           = best_cost_q;
  assign iteration_count     = iter_q;

endmodule

// File: tb/tb_solver_assignment_controller.sv
// Directed bench for solver_assignment_controller with a cycle-level
// reference model compared on every falling edge.
module tb_solver_assignment_controller;
  localparam int ASSIGN_W = 20;
  localparam int COST_W   = 8;
  localparam int ITER_W   = 16;
  localparam int ITER_MAX = (1 << ITER_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [ASSIGN_W-1:0] initial_assignment;
  logic [COST_W-1:0]   initial_cost;
  logic [ITER_W-1:0]   max_iterations;
  logic [7:0]          temperature;
  logic [ASSIGN_W-1:0] current_assignment;
  logic [COST_W-1:0]   current_cost;
  logic [ASSIGN_W-1:0] solution;
  logic [COST_W-1:0]   best_cost;
  logic [ITER_W-1:0]   iteration_count;
  logic                busy, done, solved;

  solver_assignment_controller_if #(.ASSIGN_W(ASSIGN_W), .COST_WIDTH(COST_W)) pif ();

  solver_assignment_controller dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .initial_assignment (initial_assignment),
    .initial_cost       (initial_cost),
    .max_iterations     (max_iterations),
    .temperature        (temperature),
    .prop               (pif),
    .current_assignment (current_assignment),
    .current_cost       (current_cost),
    .solution           (solution),
    .best_cost          (best_cost),
    .iteration_count    (iteration_count),
    .busy               (busy),
    .done               (done),
    .solved             (solved)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 running, 2 finished.
  int m_phase = 0;
  int m_cur_asg = 0, m_cur_cost = 0, m_sol = 0, m_best = 0;
  int m_iter = 0, m_max = 0, m_temp = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cur_asg = 0; m_cur_cost = 0; m_sol = 0; m_best = 0;
      m_iter = 0; m_max = 0; m_temp = 0;
    end else if (start && m_phase != 1) begin
      m_cur_asg  = int'(initial_assignment);
      m_sol      = int'(initial_assignment);
      m_cur_cost = int'(initial_cost);
      m_best     = int'(initial_cost);
      m_iter     = 0;
      m_max      = int'(max_iterations);
      m_temp     = int'(temperature);
      m_phase    = (m_cur_cost == 0 || m_max == 0) ? 2 : 1;
    end else if (m_phase == 1 && pif.prop_valid) begin
      int pc, delta, limit;
      bit take;
      pc    = int'(pif.prop_cost);
      delta = pc - m_cur_cost;
      limit = (delta >= 8) ? 0 : m_temp / (1 << delta);
      take  = (pc <= m_cur_cost) || (int'(pif.rand_byte) < limit);
      if (m_iter < ITER_MAX) m_iter++;
      if (pc < m_best) begin
        m_best = pc;
        m_sol  = int'(pif.prop_assignment);
      end
      if (take) begin
        m_cur_cost = pc;
        m_cur_asg  = int'(pif.prop_assignment);
      end
      if ((take && pc == 0) || m_iter == m_max) m_phase = 2;
    end
  end

  always @(negedge clk) begin
    check("m_ready",    64'(pif.prop_ready),     64'(m_phase == 1));
    check("m_busy",     64'(busy),               64'(m_phase == 1));
    check("m_done",     64'(done),               64'(m_phase == 2));
    check("m_solved",   64'(solved),             64'(m_phase == 2 && m_best == 0));
    check("m_cur_asg",  64'(current_assignment), 64'(m_cur_asg));
    check("m_cur_cost", 64'(current_cost),       64'(m_cur_cost));
    check("m_solution", 64'(solution),           64'(m_sol));
    check("m_best",     64'(best_cost),          64'(m_best));
    check("m_iter",     64'(iteration_count),    64'(m_iter));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ASSIGN_W-1:0] a, input int cost, input int maxit, input int temp);
    start = 1'b1; initial_assignment = a; initial_cost = COST_W'(cost);
    max_iterations = ITER_W'(maxit); temperature = 8'(temp);
    tick();
    start = 1'b0;
  endtask

  task automatic propose(input logic [ASSIGN_W-1:0] a, input int cost, input int rb);
    pif.prop_valid = 1'b1; pif.prop_assignment = a;
    pif.prop_cost = COST_W'(cost); pif.rand_byte = 8'(rb);
    tick();
    pif.prop_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; initial_assignment = '0; initial_cost = '0;
    max_iterations = '0; temperature = '0;
    pif.prop_valid = 1'b0; pif.prop_assignment = '0; pif.prop_cost = '0; pif.rand_byte = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cost", 64'(current_cost), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", 64'(pif.prop_ready), 64'd0);

    // Seed test: costs 4, 6, 3 at temperature 0.
    do_start(20'hA0001, 5, 10, 0);
    check("seed_busy", 64'(busy), 64'd1);
    propose(20'h00004, 4, 0); check("seed_c1", 64'(current_cost), 64'd4);
    propose(20'h00006, 6, 0); check("seed_c2", 64'(current_cost), 64'd4);
    propose(20'h00003, 3, 0); check("seed_c3", 64'(current_cost), 64'd3);
    check("seed_best", 64'(best_cost), 64'd3);
    check("seed_iter", 64'(iteration_count), 64'd3);
    check("seed_busy2", 64'(busy), 64'd1);

    // Solve test: bring current cost to 2, then a zero-cost candidate.
    propose(20'h00002, 2, 0);
    propose(20'h5C0DE, 0, 0);
    check("solve_done", 64'(done), 64'd1);
    check("solve_solved", 64'(solved), 64'd1);
    check("solve_sol", 64'(solution), 64'h5C0DE);
    check("solve_ready", 64'(pif.prop_ready), 64'd0);

    // Metropolis test at temperature 200 around current cost 3.
    do_start(20'hB0003, 3, 20, 200);
    propose(20'h0000C, 12, 0);  check("met_c12_rej", 64'(current_cost), 64'd3);
    propose(20'h00550, 5, 50);  check("met_rb50_rej", 64'(current_cost), 64'd3);
    propose(20'h00549, 5, 49);  check("met_rb49_acc", 64'(current_cost), 64'd5);
    check("met_asg", 64'(current_assignment), 64'h00549);
    check("met_best", 64'(best_cost), 64'd3);

    // Start while running must be ignored.
    do_start(20'hFFFFF, 9, 2, 1);
    check("run_start_cost", 64'(current_cost), 64'd5);
    check("run_start_iter", 64'(iteration_count), 64'd3);

    // prop_valid held high: one consumption per cycle, then budget ends it.
    pif.prop_valid = 1'b1; pif.prop_assignment = 20'h00009;
    pif.prop_cost = 8'd9; pif.rand_byte = 8'd255;
    for (int i = 0; i < 5; i++) tick();
    check("hold_iter8", 64'(iteration_count), 64'd8);
    for (int i = 0; i < 40 && !done; i++) tick();
    check("hold_done", 64'(done), 64'd1);
    check("hold_iter20", 64'(iteration_count), 64'd20);
    tick(); tick();
    check("done_ignore_valid", 64'(iteration_count), 64'd20);
    pif.prop_valid = 1'b0;

    // Budget test: four rejected cost-7 candidates against seed cost 3.
    do_start(20'hC0FFE, 3, 4, 0);
    for (int i = 0; i < 3; i++) propose(20'h00007, 7, 0);
    check("bud_busy3", 64'(busy), 64'd1);
    propose(20'h00007, 7, 0);
    check("bud_done", 64'(done), 64'd1);
    check("bud_solved", 64'(solved), 64'd0);
    check("bud_iter", 64'(iteration_count), 64'd4);
    check("bud_sol", 64'(solution), 64'hC0FFE);

    // Boundary: zero seed cost and zero budget both finish immediately.
    do_start(20'h12345, 0, 10, 0);
    check("zc_done", 64'(done), 64'd1);
    check("zc_solved", 64'(solved), 64'd1);
    do_start(20'h54321, 6, 0, 0);
    check("zi_done", 64'(done), 64'd1);
    check("zi_solved", 64'(solved), 64'd0);

    // Reset mid-run between edges.
    do_start(20'h0ABCD, 6, 10, 50);
    propose(20'h00005, 5, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_ready", 64'(pif.prop_ready), 64'd0);
    check("ar_cost", 64'(current_cost), 64'd0);
    check("ar_sol", 64'(solution), 64'd0);
    check("ar_iter", 64'(iteration_count), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    check("ar_idle_done", 64'(done), 64'd0);
    do_start(20'h0BEEF, 4, 10, 0);
    check("ar_restart_busy", 64'(busy), 64'd1);
    propose(20'h00001, 1, 0);
    check("ar_restart_cost", 64'(current_cost), 64'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
